// File: rtl/mips_pkg.sv
// Shared definitions for the memory arbiter.
//   arb_state_e          : arbiter FSM state encoding (IDLE=0, GNT_CPU=1, GNT_DBG=2)
//   STARVE_LIMIT_DEFAULT : default limit on consecutive CPU grants while debug waits
//   starve_cnt_width()   : width of a counter that must hold 0..limit
package mips_pkg;

   localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_CPU = 2'd1,
      GNT_DBG = 2'd2
   } arb_state_e;

   function automatic int unsigned starve_cnt_width(input int unsigned limit);
      return (limit > 0) ? $clog2(limit + 1) : 1;
   endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// Grant decision for the memory arbiter (purely combinational).
// Picks the next FSM state from the two requests and the starvation count,
// and computes the next starvation count.
//   cpu_req, dbg_req  : in  - pending requests
//   starve_cnt        : in  - consecutive CPU grants issued while debug waited
//   next_state        : out - arb_state_e encoding of the next grant
//   starve_cnt_next   : out - updated starvation count
module arb_prio_sel
   import mips_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
   parameter int unsigned CNT_W        = starve_cnt_width(STARVE_LIMIT)
) (
   input  logic             cpu_req,
   input  logic             dbg_req,
   input  logic [CNT_W-1:0] starve_cnt,
   output logic [1:0]       next_state,
   output logic [CNT_W-1:0] starve_cnt_next
);

   arb_state_e nxt;
   logic       starved;

   always_comb begin
      starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

      // CPU has priority on conflict until debug has waited STARVE_LIMIT grants
      nxt = IDLE;
      if (cpu_req && dbg_req) begin
         nxt = starved ? GNT_DBG : GNT_CPU;
      end else if (cpu_req) begin
         nxt = GNT_CPU;
      end else if (dbg_req) begin
         nxt = GNT_DBG;
      end

      starve_cnt_next = starve_cnt;
      if (!dbg_req || nxt == GNT_DBG) begin
         starve_cnt_next = '0;
      end else if (nxt == GNT_CPU && !starved) begin
         starve_cnt_next = starve_cnt + CNT_W'(1);
      end

      next_state = nxt;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter (CPU and debug) in front of a single combinational-read
// data memory. CPU wins conflicts except when debug has waited STARVE_LIMIT
// consecutive CPU grants. Each ack cycle performs exactly one access; writes
// commit at the edge that ends the ack cycle.
//   clk, reset                         : clock, synchronous active-high reset
//   cpu_req/we/addr/wd, cpu_ack/stall  : CPU port
//   dbg_req/we/addr/wd, dbg_ack        : debug port
//   rdata                              : read data (valid with an ack)
//   mem_we/addr/wd, mem_rd             : memory interface
//   conflict_cnt                       : only with MEM_ARB_CONFLICT_CNT_EN defined;
//                                        saturating count of dual-request edges
module mem_arbiter
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [WIDTH-1:0] cpu_addr,
   input  logic [WIDTH-1:0] cpu_wd,
   output logic             cpu_ack,
   output logic             cpu_stall,
   input  logic             dbg_req,
   input  logic             dbg_we,
   input  logic [WIDTH-1:0] dbg_addr,
   input  logic [WIDTH-1:0] dbg_wd,
   output logic             dbg_ack,
`ifdef MEM_ARB_CONFLICT_CNT_EN
   output logic [15:0]      conflict_cnt,
`endif
   output logic [WIDTH-1:0] rdata,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wd,
   input  logic [WIDTH-1:0] mem_rd
);

   localparam int unsigned CNT_W = starve_cnt_width(STARVE_LIMIT);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic [1:0]       sel_next;

   arb_prio_sel #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CNT_W        (CNT_W)
   ) u_prio_sel (
      .cpu_req         (cpu_req),
      .dbg_req         (dbg_req),
      .starve_cnt      (starve_q),
      .next_state      (sel_next),
      .starve_cnt_next (starve_d)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = arb_state_e'(sel_next);
   end

   // Outputs. Reset masks the grant so an access in flight is dropped
   // without a write at the reset edge.
   always_comb begin
      cpu_ack  = 1'b0;
      dbg_ack  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
      unique case (state_q)
         GNT_CPU: begin
            cpu_ack = ~reset;
            mem_we  = cpu_we & ~reset;
         end
         GNT_DBG: begin
            dbg_ack  = ~reset;
            mem_we   = dbg_we & ~reset;
            mem_addr = dbg_addr;
            mem_wd   = dbg_wd;
         end
         default: ;
      endcase
   end

   assign cpu_stall = cpu_req & ~cpu_ack;
   assign rdata     = mem_rd;

`ifdef MEM_ARB_CONFLICT_CNT_EN
   logic [15:0] conflict_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         conflict_q <= '0;
      end else if (cpu_req && dbg_req && conflict_q != 16'hFFFF) begin
         conflict_q <= conflict_q + 16'd1;
      end
   end

   assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a cycle table of directed vectors with
// hand-computed acks / mem_we, plus hand-written multi-cycle sequences.
module tb_mem_arbiter;

   localparam logic [31:0] CPU_ADDR = 32'h0000_0004;
   localparam logic [31:0] CPU_WD   = 32'hC0C0_0001;
   localparam logic [31:0] DBG_ADDR = 32'h0000_0008;
   localparam logic [31:0] DBG_WD   = 32'hDB60_0002;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [31:0] cpu_addr, cpu_wd, dbg_addr, dbg_wd;
   logic        cpu_ack, cpu_stall, dbg_ack;
   logic [31:0] rdata, mem_addr, mem_wd, mem_rd;
   logic        mem_we;
`ifdef MEM_ARB_CONFLICT_CNT_EN
   logic [15:0] conflict_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .WIDTH        (32),
      .STARVE_LIMIT (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wd    (cpu_wd),
      .cpu_ack   (cpu_ack),
      .cpu_stall (cpu_stall),
      .dbg_req   (dbg_req),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wd    (dbg_wd),
      .dbg_ack   (dbg_ack),
`ifdef MEM_ARB_CONFLICT_CNT_EN
      .conflict_cnt (conflict_cnt),
`endif
      .rdata     (rdata),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wd    (mem_wd),
      .mem_rd    (mem_rd)
   );

   // Memory model: combinational read, write at rising edge
   logic [31:0] mem [256];
   logic        mem_init;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 | i;
      end else if (mem_we) begin
         mem[mem_addr[7:0]] <= mem_wd;
      end
   end

   assign mem_rd = mem[mem_addr[7:0]];

   // Row bits: rst creq cwe dreq dwe | exp cpu_ack dbg_ack mem_we
   typedef struct packed {
      logic rst;
      logic creq;
      logic cwe;
      logic dreq;
      logic dwe;
      logic cack;
      logic dack;
      logic we;
   } vec_t;

   vec_t tbl [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          cpu_run;
      int          we_cycles;
      logic        seen_dbg;
      logic [31:0] exp_addr;

      tbl[0]  = 8'b1_1_0_1_0_0_0_0;  // reset held, both requesting
      tbl[1]  = 8'b1_1_0_1_0_0_0_0;
      tbl[2]  = 8'b0_1_0_1_0_0_0_0;  // reset dropped, still IDLE
      tbl[3]  = 8'b0_1_0_1_0_1_0_0;  // CPU x4
      tbl[4]  = 8'b0_1_0_1_0_1_0_0;
      tbl[5]  = 8'b0_1_0_1_0_1_0_0;
      tbl[6]  = 8'b0_1_0_1_0_1_0_0;
      tbl[7]  = 8'b0_1_0_1_0_0_1_0;  // DBG
      tbl[8]  = 8'b0_1_1_1_0_1_0_1;  // CPU x4 (first one writes)
      tbl[9]  = 8'b0_1_0_1_0_1_0_0;
      tbl[10] = 8'b0_1_0_1_0_1_0_0;
      tbl[11] = 8'b0_1_0_1_0_1_0_0;
      tbl[12] = 8'b0_1_0_1_1_0_1_1;  // DBG write
      tbl[13] = 8'b0_0_0_0_0_1_0_0;  // grant made at previous edge still shows
      tbl[14] = 8'b0_0_0_0_0_0_0_0;
      tbl[15] = 8'b0_0_0_1_0_0_0_0;  // debug alone: cycle 1
      tbl[16] = 8'b0_0_0_1_1_0_1_1;  // cycle 2
      tbl[17] = 8'b0_0_0_1_0_0_1_0;  // cycle 3
      tbl[18] = 8'b0_0_0_0_0_0_1_0;  // req high at previous edge re-grants
      tbl[19] = 8'b0_0_0_0_0_0_0_0;

      reset    = 1'b1;
      cpu_req  = 1'b0;
      cpu_we   = 1'b0;
      dbg_req  = 1'b0;
      dbg_we   = 1'b0;
      cpu_addr = CPU_ADDR;
      cpu_wd   = CPU_WD;
      dbg_addr = DBG_ADDR;
      dbg_wd   = DBG_WD;
      mem_init = 1'b1;
      step();
      mem_init = 1'b0;

      for (int r = 0; r < 20; r++) begin
         step();
         reset   = tbl[r].rst;
         cpu_req = tbl[r].creq;
         cpu_we  = tbl[r].cwe;
         dbg_req = tbl[r].dreq;
         dbg_we  = tbl[r].dwe;
         @(negedge clk);
         exp_addr = tbl[r].dack ? DBG_ADDR : CPU_ADDR;
         chk($sformatf("row%0d cpu_ack", r), 32'(cpu_ack), 32'(tbl[r].cack));
         chk($sformatf("row%0d dbg_ack", r), 32'(dbg_ack), 32'(tbl[r].dack));
         chk($sformatf("row%0d mem_we", r), 32'(mem_we), 32'(tbl[r].we));
         chk($sformatf("row%0d cpu_stall", r), 32'(cpu_stall),
             32'(tbl[r].creq & ~tbl[r].cack));
         chk($sformatf("row%0d mem_addr", r), mem_addr, exp_addr);
         chk($sformatf("row%0d mem_wd", r), mem_wd, tbl[r].dack ? DBG_WD : CPU_WD);
         chk($sformatf("row%0d rdata", r), rdata, mem[exp_addr[7:0]]);
      end

      // CPU write 0xDEADBEEF to 0x10, then read it back
      we_cycles = 0;
      step();
      cpu_req  = 1'b1;
      cpu_we   = 1'b1;
      cpu_addr = 32'h10;
      cpu_wd   = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("wr latency cpu_ack", 32'(cpu_ack), 32'd0);
      we_cycles += int'(mem_we);
      step();
      @(negedge clk);
      chk("wr cpu_ack", 32'(cpu_ack), 32'd1);
      chk("wr mem_we", 32'(mem_we), 32'd1);
      chk("wr mem_addr", mem_addr, 32'h10);
      we_cycles += int'(mem_we);
      step();
      cpu_we = 1'b0;
      @(negedge clk);
      chk("rd cpu_ack", 32'(cpu_ack), 32'd1);
      chk("rd rdata", rdata, 32'hDEAD_BEEF);
      we_cycles += int'(mem_we);
      step();
      cpu_req = 1'b0;
      @(negedge clk);
      we_cycles += int'(mem_we);
      step();
      @(negedge clk);
      chk("rw idle cpu_ack", 32'(cpu_ack), 32'd0);
      we_cycles += int'(mem_we);
      chk("rw mem_we cycles", 32'(we_cycles), 32'd1);

      // Reset during a debug write cycle drops the write
      step();
      dbg_req  = 1'b1;
      dbg_we   = 1'b1;
      dbg_addr = 32'h30;
      dbg_wd   = 32'hAAAA_5555;
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("rst-wr mem_we", 32'(mem_we), 32'd0);
      chk("rst-wr dbg_ack", 32'(dbg_ack), 32'd0);
      step();
      reset    = 1'b0;
      dbg_req  = 1'b0;
      dbg_we   = 1'b0;
      cpu_addr = 32'h30;
      @(negedge clk);
      chk("rst-wr after dbg_ack", 32'(dbg_ack), 32'd0);
      chk("rst-wr old value", rdata, 32'h1000_0030);

      // Starvation count clears when debug drops its request
      cpu_addr = CPU_ADDR;
      step();
      cpu_req = 1'b1;
      dbg_req = 1'b1;
      step();
      step();
      dbg_req = 1'b0;
      step();
      dbg_req  = 1'b1;
      cpu_run  = 0;
      seen_dbg = 1'b0;
      for (int c = 0; c < 20 && !seen_dbg; c++) begin
         @(negedge clk);
         if (dbg_ack) seen_dbg = 1'b1;
         else if (cpu_ack) cpu_run++;
         step();
      end
      chk("starve clear dbg granted", 32'(seen_dbg), 32'd1);
      chk("starve clear cpu run", 32'(cpu_run), 32'd5);
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      step();
      step();

`ifdef MEM_ARB_CONFLICT_CNT_EN
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("conflict_cnt reset", 32'(conflict_cnt), 32'd0);
      cpu_req = 1'b1;
      dbg_req = 1'b1;
      for (int c = 0; c < 10; c++) @(posedge clk);
      #1;
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      @(negedge clk);
      chk("conflict_cnt 10", 32'(conflict_cnt), 32'd10);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
